opb_register_bank_ppc2simulink: RTL and testbench

Parametrised OPB slave register bank that supersedes the single-register PPC-to-Simulink bridge. It exposes N_REGS software-writable 32-bit control words to fabric, each with byte-enable support and a one-cycle update strobe. It also provides N_IN read-only status words sampled from fabric. One clock domain (OPB_Clk); fabric logic using it runs on OPB_Clk.

---
 rtl/opb_register_bank_ppc2simulink.sv | 143 ++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: N_REGS byte-writable control words, N_IN status words.
// Define OPB_REG_SNAPSHOT_EN for coherent multi-word status reads via snapshot.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01094100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010941FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter int          N_REGS       = 4,
  parameter int          N_IN         = 2,
  parameter logic [31:0] RESET_VAL    = 32'h00000000
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst,
  input  logic [0:31]            OPB_ABus,
  input  logic [0:3]             OPB_BE,
  input  logic [0:31]            OPB_DBus,
  input  logic                   OPB_RNW,
  input  logic                   OPB_select,
  input  logic                   OPB_seqAddr,
  output logic [0:31]            Sl_DBus,
  output logic                   Sl_errAck,
  output logic                   Sl_retry,
  output logic                   Sl_toutSup,
  output logic                   Sl_xferAck,
  output logic [N_REGS*32-1:0]   user_data_out,
  output logic [N_REGS-1:0]      user_wr_strobe,
  input  logic [N_IN*32-1:0]     user_data_in
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam bit IS_V5 = (C_FAMILY == "virtex5");

  state_t                    state;
  logic [C_OPB_AWIDTH-1:0]   addr;
  logic [C_OPB_DWIDTH-1:0]   wdata;
  logic [3:0]                be;
  logic [31:0]               off;
  logic [29:0]               idx;
  logic                      hit;
  logic [31:0]               rd;
  logic [31:0]               dbus;
  logic                      ack;
  logic [N_REGS-1:0]         strobe;
  logic [31:0]               ctrl [N_REGS];
  logic                      unused;

  // Plain assignment maps OPB bit 0 onto the MSB of each word.
  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;
  assign off   = addr - C_BASEADDR;
  assign idx   = off[31:2];
  assign hit   = OPB_select && (addr >= C_BASEADDR)
              && (addr <= C_HIGHADDR);

`ifdef OPB_REG_SNAPSHOT_EN
  logic [N_IN*32-1:0] snap;
  logic               snap_take;

  assign snap_take = (N_IN > 0) && hit && OPB_RNW
                  && (idx == 30'(N_REGS));

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      snap <= '0;
    end else if (state == IDLE && snap_take) begin
      snap <= user_data_in;
    end
  end
`endif

  always_comb begin
    rd = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (idx == 30'(k)) rd = ctrl[k];
    end
    for (int j = 0; j < N_IN; j++) begin
      if (idx == 30'(N_REGS + j)) begin
`ifdef OPB_REG_SNAPSHOT_EN
        rd = (j == 0) ? user_data_in[31:0] : snap[32*j +: 32];
`else
        rd = user_data_in[32*j +: 32];
`endif
      end
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state  <= IDLE;
      ack    <= 1'b0;
      dbus   <= '0;
      strobe <= '0;
      for (int k = 0; k < N_REGS; k++) ctrl[k] <= RESET_VAL;
    end else begin
      ack    <= 1'b0;
      dbus   <= '0;
      strobe <= '0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            state <= ACK;
            ack   <= 1'b1;
            if (OPB_RNW) begin
              dbus <= rd;
            end else begin
              for (int k = 0; k < N_REGS; k++) begin
                if (idx == 30'(k)) begin
                  strobe[k] <= 1'b1;
                  for (int i = 0; i < 4; i++) begin
                    if (be[i]) ctrl[k][8*i +: 8] <= wdata[8*i +: 8];
                  end
                end
              end
            end
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_out
    assign user_data_out[32*k +: 32] = ctrl[k];
  end

  assign Sl_DBus        = dbus;
  assign Sl_xferAck     = ack;
  assign user_wr_strobe = strobe;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

`ifdef OPB_REG_SNAPSHOT_EN
  assign unused = ^{OPB_seqAddr, off[1:0], IS_V5, snap[31:0]};
`else
  assign unused = ^{OPB_seqAddr, off[1:0], IS_V5};
`endif

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed self-checking bench for opb_register_bank_ppc2simulink.
// Expected values are hand-computed from the register map and byte-enable rules.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01094100;
  localparam logic [31:0] HIGH = 32'h010941FF;
  localparam logic [31:0] RV   = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:31]   abus;
  logic [0:3]    be;
  logic [0:31]   wdat;
  logic          rnw;
  logic          sel;
  logic          seq;
  logic [0:31]   sl_dbus;
  logic          err_ack;
  logic          retry;
  logic          tout_sup;
  logic          xfer_ack;
  logic [127:0]  udo;
  logic [3:0]    strb;
  logic [63:0]   udi;

  int            n_cmp = 0;
  int            n_err = 0;
  logic          bad_tie = 1'b0;

  logic          ack_v;
  logic [31:0]   dbus_v;
  logic [3:0]    strb_v;
  logic [5:0]    pat;

  opb_register_bank_ppc2simulink #(
    .RESET_VAL(RV)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (wdat),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_errAck     (err_ack),
    .Sl_retry      (retry),
    .Sl_toutSup    (tout_sup),
    .Sl_xferAck    (xfer_ack),
    .user_data_out (udo),
    .user_wr_strobe(strb),
    .user_data_in  (udi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) bad_tie <= bad_tie | err_ack | retry | tout_sup;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer: outputs checked idle before and after, ack cycle captured.
  task automatic xfer(input logic [31:0] a, input logic r,
                      input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    abus = a; rnw = r; be = b; wdat = d; sel = 1'b1;
    check("pre_ack", 128'(xfer_ack), 128'd0);
    check("pre_dbus", 128'(sl_dbus), 128'd0);
    @(negedge clk);
    ack_v  = xfer_ack;
    dbus_v = sl_dbus;
    strb_v = strb;
    sel = 1'b0;
    @(negedge clk);
    check("post_ack", 128'(xfer_ack), 128'd0);
    check("post_dbus", 128'(sl_dbus), 128'd0);
    check("post_strb", 128'(strb), 128'd0);
  endtask

  initial begin
    rst = 1'b1; abus = '0; be = '0; wdat = '0;
    rnw = 1'b0; sel = 1'b0; seq = 1'b0; udi = '0;
    repeat (2) @(negedge clk);
    check("rst_udo", udo, {4{RV}});
    check("rst_ack", 128'(xfer_ack), 128'd0);
    check("rst_dbus", 128'(sl_dbus), 128'd0);
    check("rst_strb", 128'(strb), 128'd0);
    rst = 1'b0;

    xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'h12345678);
    check("wr_ack", 128'(ack_v), 128'd1);
    check("wr_strb", 128'(strb_v), 128'h4);
    check("wr_word2", 128'(udo[95:64]), 128'h12345678);

    xfer(BASE + 32'h8, 1'b0, 4'b0101, 32'hFFFFFFFF);
    check("be_strb", 128'(strb_v), 128'h4);
    check("be_word2", 128'(udo[95:64]), 128'h12FF56FF);

    xfer(BASE + 32'h8, 1'b1, 4'b0000, 32'h0);
    check("rd_ack", 128'(ack_v), 128'd1);
    check("rd_word2", 128'(dbus_v), 128'h12FF56FF);
    check("rd_strb", 128'(strb_v), 128'd0);

    @(negedge clk);
    abus = BASE; rnw = 1'b1; sel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      pat[i] = xfer_ack;
    end
    sel = 1'b0;
    repeat (2) @(negedge clk);
    check("held_pattern", 128'(pat), 128'(6'b101010));

    udi = {32'h0, 32'hDEADBEEF};
    xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0);
    check("st_ack", 128'(ack_v), 128'd1);
    check("st_rd", 128'(dbus_v), 128'hDEADBEEF);

    xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'h11111111);
    check("st_wr_ack", 128'(ack_v), 128'd1);
    check("st_wr_strb", 128'(strb_v), 128'd0);
    check("st_wr_udo", udo, {RV, 32'h12FF56FF, RV, RV});

    xfer(BASE + 32'h40, 1'b1, 4'b1111, 32'h0);
    check("unmap_ack", 128'(ack_v), 128'd1);
    check("unmap_rd", 128'(dbus_v), 128'd0);

    xfer(HIGH, 1'b0, 4'b1111, 32'h77777777);
    check("high_ack", 128'(ack_v), 128'd1);
    check("high_strb", 128'(strb_v), 128'd0);

    xfer(HIGH + 32'h1, 1'b1, 4'b1111, 32'h0);
    check("miss_hi_ack", 128'(ack_v), 128'd0);

    xfer(BASE - 32'h4, 1'b0, 4'b1111, 32'h33333333);
    check("miss_lo_ack", 128'(ack_v), 128'd0);
    check("miss_lo_strb", 128'(strb_v), 128'd0);
    check("miss_udo", udo, {RV, 32'h12FF56FF, RV, RV});

    xfer(BASE + 32'h3, 1'b0, 4'b0000, 32'hFFFFFFFF);
    check("be0_strb", 128'(strb_v), 128'h1);
    check("be0_udo", udo, {RV, 32'h12FF56FF, RV, RV});

    xfer(BASE + 32'hC, 1'b0, 4'b1000, 32'h9C000000);
    check("msb_word3", 128'(udo[127:96]), 128'h9CA5A5A5);

    udi = {32'h1, 32'hDEADBEEF};
    xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0);
    check("snap_w0", 128'(dbus_v), 128'hDEADBEEF);
    udi = {32'h2, 32'hDEADBEEF};
    xfer(BASE + 32'h14, 1'b1, 4'b1111, 32'h0);
`ifdef OPB_REG_SNAPSHOT_EN
    check("snap_w1", 128'(dbus_v), 128'h1);
`else
    check("live_w1", 128'(dbus_v), 128'h2);
`endif

    @(negedge clk);
    abus = BASE + 32'h8; rnw = 1'b1; sel = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    check("rack_ack", 128'(xfer_ack), 128'd1);
    check("rack_dbus", 128'(sl_dbus), 128'h12FF56FF);
    rst = 1'b1;
    #1;
    check("rack_rst_ack", 128'(xfer_ack), 128'd0);
    check("rack_rst_dbus", 128'(sl_dbus), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    abus = BASE + 32'h4; rnw = 1'b0; be = 4'b1111;
    wdat = 32'h0BADF00D; sel = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    check("wack_strb", 128'(strb), 128'h2);
    rst = 1'b1;
    #1;
    check("wack_rst_strb", 128'(strb), 128'd0);
    check("wack_rst_ack", 128'(xfer_ack), 128'd0);
    check("wack_rst_udo", udo, {4{RV}});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("tied_outputs", 128'(bad_tie), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
